// File: rtl/mcpu_alu_mc.sv
// Multi-cycle MCPU ALU. Single-cycle logic/arithmetic ops, iterative 1-bit/cycle
// shifts and rotate, and a shift-add multiplier behind a start/busy/done handshake.
module mcpu_alu_mc #(
   parameter int DATA_WIDTH = 32,
   parameter int SHAMT_W    = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [3:0]            op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic [SHAMT_W-1:0]    amount,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] d_out,
   output logic                  carry_out,
   output logic                  zero_out
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = SHAMT_W + 1;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_PA  = 4'b0101;
   localparam logic [3:0] OP_PB  = 4'b0110;
   localparam logic [3:0] OP_SHL = 4'b1000;
   localparam logic [3:0] OP_SHR = 4'b1001;
   localparam logic [3:0] OP_ASR = 4'b1010;
   localparam logic [3:0] OP_ROL = 4'b1011;
   localparam logic [3:0] OP_MUL = 4'b1100;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;

   state_t           r_state, w_state_nxt;
   logic             w_accept, w_fin;
   logic             r_pend, r_done, r_carry, r_zero;
   logic [3:0]       r_op;
   logic [W-1:0]     r_a, r_b, r_sh, r_dout;
   logic [2*W-1:0]   r_acc;
   logic [CW-1:0]    r_cnt;
   logic [W:0]       w_single, w_step;
   logic [2*W-1:0]   w_mul;
   logic [W-1:0]     w_res;
   logic             w_res_c;

   // Returns {carry, result}; a shift with amount 0 lands here and passes a through.
   function automatic logic [W:0] alu_single(input logic [3:0] f, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
      logic [W:0] r;
      case (f)
         OP_ADD:  r = {1'b0, x} + {1'b0, y};
         OP_SUB:  r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
         OP_AND:  r = {1'b0, x & y};
         OP_OR:   r = {1'b0, x | y};
         OP_XOR:  r = {1'b0, x ^ y};
         OP_PA:   r = {1'b0, x};
         OP_PB:   r = {1'b0, y};
         OP_SHL, OP_SHR, OP_ASR, OP_ROL: r = {1'b0, x};
         default: r = '0;
      endcase
      return r;
   endfunction

   // One shift/rotate step: {bit shifted out, new value}.
   function automatic logic [W:0] shift_step(input logic [1:0] f, input logic [W-1:0] v);
      logic [W:0] r;
      case (f)
         2'b00:   r = {v[W-1], v[W-2:0], 1'b0};
         2'b01:   r = {v[0], 1'b0, v[W-1:1]};
         2'b10:   r = {v[0], v[W-1], v[W-1:1]};
         default: r = {v[W-1], v[W-2:0], v[W-1]};
      endcase
      return r;
   endfunction

   // One shift-add iteration; the adder carry becomes the new accumulator MSB.
   function automatic logic [2*W-1:0] mul_step(input logic [2*W-1:0] acc, input logic [W-1:0] x);
      logic [W:0] s;
      s = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? x : {W{1'b0}})};
      return {s, acc[W-1:1]};
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_fin       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               if (op == OP_MUL)
                  w_state_nxt = S_MUL;
               else if (op[3:2] == 2'b10 && amount != '0)
                  w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT, S_MUL: begin
            if (r_cnt == CW'(1)) begin
               w_fin       = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_single = alu_single(r_op, r_a, r_b);
      w_step   = shift_step(r_op[1:0], r_sh);
      w_mul    = mul_step(r_acc, r_a);
      w_res    = w_single[W-1:0];
      w_res_c  = w_single[W];
      if (r_state == S_SHIFT) begin
         w_res   = w_step[W-1:0];
         w_res_c = w_step[W];
      end else if (r_state == S_MUL) begin
         w_res   = w_mul[W-1:0];
         w_res_c = |w_mul[2*W-1:W];
      end
   end

   // Operand capture and iteration state
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_op  <= op;
         r_a   <= a;
         r_b   <= b;
         r_sh  <= a;
         r_acc <= {{W{1'b0}}, b};
         r_cnt <= (op == OP_MUL) ? CW'(W) : {1'b0, amount};
      end else if (r_state == S_SHIFT) begin
         r_sh  <= w_step[W-1:0];
         r_cnt <= r_cnt - CW'(1);
      end else if (r_state == S_MUL) begin
         r_acc <= w_mul;
         r_cnt <= r_cnt - CW'(1);
      end
   end

   // Result registers: written only on the edge that raises done
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend  <= 1'b0;
         r_done  <= 1'b0;
         r_dout  <= '0;
         r_carry <= 1'b0;
         r_zero  <= 1'b0;
      end else begin
         r_pend <= w_accept && (w_state_nxt == S_IDLE);
         r_done <= r_pend | w_fin;
         if (r_pend | w_fin) begin
            r_dout  <= w_res;
            r_carry <= w_res_c;
            r_zero  <= (w_res == '0);
         end
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign d_out     = r_dout;
   assign carry_out = r_carry;
   assign zero_out  = r_zero;

endmodule
